// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encodings,
// default data/timeout parameters and a small width helper.
package spi_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 1023;

    // Bits needed to hold values 0..count-1, never less than one bit.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req upward from pointer p
// (modulo N) and reports the first requester found.
module spi_rr_pick
    import spi_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = index_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] p,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          any
);

    // Rotating priority search; the first hit stops further updates.
    always_comb begin
        int            pos;
        logic [IW-1:0] sel;
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        pos    = 0;
        sel    = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(p) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            sel = pos[IW-1:0];
            if (!any && req[sel]) begin
                any         = 1'b1;
                onehot[sel] = 1'b1;
                index       = sel;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// SPI arbiter: shares one spi_master between N requesters using a
// round-robin grant, one transaction at a time, with a timeout on the
// master's completion pulse.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_tx_data,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic               err,
    output logic [WIDTH-1:0]   rx_data,
    output logic               m_ready,
    output logic [WIDTH-1:0]   m_tx_data,
    input  logic               m_valid,
    input  logic [WIDTH-1:0]   m_rx_data
);

    localparam int IW = index_width(N);
    localparam int CW = index_width(TIMEOUT + 1);

    // The counter holds the number of WAIT cycles already spent; when it
    // sits one below TIMEOUT the current cycle is the last one allowed.
    localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    win_idx;
    logic [CW-1:0]    cnt;

    logic [N-1:0]     pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] sel_tx;

    spi_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .p      (ptr),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // Select the tx word belonging to the requester the picker chose.
    always_comb begin
        sel_tx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_tx = req_tx_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Transaction FSM with registered grant, handshake, timeout and result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rx_data   <= '0;
            m_ready   <= 1'b0;
            m_tx_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        win_idx   <= pick_idx;
                        gnt       <= pick_onehot;
                        m_ready   <= 1'b1;
                        m_tx_data <= sel_tx;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    m_ready <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_valid) begin
                        rx_data <= m_rx_data;
                        err     <= 1'b0;
                        done    <= gnt;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_TERM) begin
                        rx_data <= '0;
                        err     <= 1'b1;
                        done    <= gnt;
                        cnt     <= cnt + CW'(1);
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                    if (win_idx == IW'(N - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= win_idx + IW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: a loopback spi_master model with
// programmable response delay, directed scenarios and randomized
// transactions checked against a round-robin reference model.
module tb_spi_arbiter;

    localparam int N       = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     req;
    logic [N*WIDTH-1:0] req_tx_data;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             err;
    logic [WIDTH-1:0] rx_data;
    logic             m_ready;
    logic [WIDTH-1:0] m_tx_data;
    logic             m_valid;
    logic [WIDTH-1:0] m_rx_data;

    int vectors   = 0;
    int failures  = 0;
    int mdl_ptr   = 0;
    int master_delay = 0;
    int stray_cnt = 0;

    spi_arbiter #(
        .N       (N),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .req_tx_data (req_tx_data),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rx_data     (rx_data),
        .m_ready     (m_ready),
        .m_tx_data   (m_tx_data),
        .m_valid     (m_valid),
        .m_rx_data   (m_rx_data)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Hard stop in case something never completes.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Loopback spi_master: echoes the tx word after master_delay WAIT cycles,
    // gives up when the arbiter finishes, and can inject stray pulses.
    initial begin
        int          cntdown;
        bit          pend;
        logic [7:0]  word;
        int          stray_seen;
        cntdown    = 0;
        pend       = 1'b0;
        word       = '0;
        stray_seen = 0;
        m_valid    = 1'b0;
        m_rx_data  = '0;
        forever begin
            @(negedge clk);
            m_valid = 1'b0;
            if (!rstn) begin
                pend = 1'b0;
            end else if (|done) begin
                pend = 1'b0;
            end else if (m_ready) begin
                pend    = 1'b1;
                cntdown = master_delay;
                word    = m_tx_data;
            end else if (pend) begin
                if (cntdown == 0) begin
                    m_valid   = 1'b1;
                    m_rx_data = word;
                    pend      = 1'b0;
                end else begin
                    cntdown--;
                end
            end
            if (stray_cnt != stray_seen) begin
                m_valid    = 1'b1;
                m_rx_data  = 8'hEE;
                stray_seen = stray_cnt;
            end
        end
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, expv);
        end
    endtask

    // Reference round-robin: first requester at or after p, ascending mod N.
    function automatic int rrModel(input logic [N-1:0] r, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One full transaction, entered and left at a negedge of an IDLE cycle.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [31:0] words,
                                 input int d, input bit hold);
        int          w;
        int          n;
        int          extra;
        int          exp_n;
        bit          timed_out;
        logic [7:0]  exp_word;
        req          = r;
        req_tx_data  = words;
        master_delay = d;
        w        = rrModel(r, mdl_ptr);
        exp_word = words[w*WIDTH +: WIDTH];
        timed_out = (d > TIMEOUT - 1);
        exp_n     = timed_out ? TIMEOUT + 1 : d + 2;

        @(negedge clk);
        checkOutput("m_ready_start", 32'(m_ready), 32'd1);
        checkOutput("gnt_start", 32'(gnt), 32'(1 << w));
        checkOutput("m_tx_data", 32'(m_tx_data), 32'(exp_word));

        n = 0;
        extra = 0;
        while (done == '0 && n < 40) begin
            @(negedge clk);
            n++;
            if (m_ready) extra++;
        end
        checkOutput("done_latency", 32'(n), 32'(exp_n));
        checkOutput("m_ready_once", 32'(extra), 32'd0);
        checkOutput("done_vec", 32'(done), 32'(1 << w));
        checkOutput("gnt_done", 32'(gnt), 32'(1 << w));
        checkOutput("err", 32'(err), 32'(timed_out));
        checkOutput("rx_data", 32'(rx_data), timed_out ? 32'd0 : 32'(exp_word));
        mdl_ptr = (w + 1) % N;
        if (!hold) req[w] = 1'b0;

        @(negedge clk);
        checkOutput("gnt_idle", 32'(gnt), 32'd0);
        checkOutput("done_idle", 32'(done), 32'd0);
    endtask

    // Check every registered output is back at its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_rx"}, 32'(rx_data), 32'd0);
        checkOutput({tag, "_mready"}, 32'(m_ready), 32'd0);
        checkOutput({tag, "_mtx"}, 32'(m_tx_data), 32'd0);
    endtask

    // Main sequence: reset, directed scenarios, then randomized traffic.
    initial begin
        req         = '0;
        req_tx_data = '0;
        rstn        = 1'b1;
        #1 rstn = 1'b0;
        #1 checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] single request with loopback");
        applyStimulus(4'b0001, 32'h000000A5, 2, 1'b0);

        $display("[TB] fairness with all requesters held");
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b1111, 32'h13121110, $urandom_range(0, 5), 1'b1);
        end

        $display("[TB] pointer wrap from port 3 to port 0");
        applyStimulus(4'b0100, 32'h44332211, 1, 1'b0);
        applyStimulus(4'b1001, 32'h9C000081, 3, 1'b0);
        applyStimulus(req, 32'h9C000081, 0, 1'b0);

        $display("[TB] timeout and terminal-count boundary");
        applyStimulus(4'b0010, 32'h00005A00, 1000, 1'b0);
        applyStimulus(4'b0010, 32'h00003C00, 0, 1'b0);
        applyStimulus(4'b0100, 32'h00770000, TIMEOUT - 1, 1'b0);
        applyStimulus(4'b1000, 32'h66000000, TIMEOUT, 1'b0);

        $display("[TB] stray m_valid while idle");
        req = '0;
        stray_cnt++;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checkOutput("stray_done", 32'(done), 32'd0);
            checkOutput("stray_mready", 32'(m_ready), 32'd0);
        end
        applyStimulus(4'b0001, 32'h000000C3, 1, 1'b0);

        $display("[TB] reset in the middle of WAIT");
        req          = 4'b0010;
        req_tx_data  = 32'h0000B700;
        master_delay = 1000;
        @(negedge clk);
        checkOutput("rst_pre_mready", 32'(m_ready), 32'd1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1 checkResetOutputs("midrst");
        req = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checkOutput("midrst_no_done", 32'(done), 32'd0);
        end
        rstn    = 1'b1;
        mdl_ptr = 0;
        @(negedge clk);
        applyStimulus(4'b0100, 32'h00D20000, 2, 1'b0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            applyStimulus(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 17), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
